// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-requester (CPU / program loader) arbiter in front of a
//            single-port synchronous-read memory. Each access runs a
//            registered arbitrate -> issue -> respond sequence.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int LDR_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  // CPU requester
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  // Loader / debug requester
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_ack,
  output logic [DATA_W-1:0] ldr_rdata,
  // Memory side
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // Status
  output logic              owner,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic last_grant;   // 0 = CPU, 1 = loader
  logic lat_we;       // write flag of the in-flight access
  logic cpu_elig;
  logic ldr_elig;
  logic grant_valid;
  logic grant_ldr;
  logic ldr_wins_tie;

  // A requester whose ack is high this cycle is ignored, so a req left high
  // through the ack cycle cannot trigger a duplicate access.
  assign cpu_elig    = cpu_req & ~cpu_ack;
  assign ldr_elig    = ldr_req & ~ldr_ack;
  assign grant_valid = cpu_elig | ldr_elig;

  generate
    if (LDR_PRIORITY != 0) begin : g_ldr_fixed_prio
      assign ldr_wins_tie = 1'b1;
    end else begin : g_round_robin
      // Loader wins a tie only if the CPU had the previous grant.
      assign ldr_wins_tie = ~last_grant;
    end
  endgenerate

  assign grant_ldr = ldr_elig & (~cpu_elig | ldr_wins_tie);

  // State register; reset aborts any in-flight access immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and phase-decoded memory strobe / busy flag.
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant_valid) begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_we    = lat_we;
        busy      = 1'b1;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        busy      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Grant latching, memory address/data registers, and response delivery.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      lat_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_ack    <= 1'b0;
      ldr_ack    <= 1'b0;
      cpu_rdata  <= '0;
      ldr_rdata  <= '0;
    end else begin
      cpu_ack <= 1'b0;
      ldr_ack <= 1'b0;
      if (state == S_IDLE && grant_valid) begin
        owner      <= grant_ldr;
        last_grant <= grant_ldr;
        lat_we     <= grant_ldr ? ldr_we    : cpu_we;
        mem_addr   <= grant_ldr ? ldr_addr  : cpu_addr;
        mem_wdata  <= grant_ldr ? ldr_wdata : cpu_wdata;
      end
      // Memory registered the address at the ISSUE->RESP edge, so its
      // read data is valid throughout RESP.
      if (state == S_RESP) begin
        if (owner) begin
          ldr_ack <= 1'b1;
          if (!lat_we) begin
            ldr_rdata <= mem_rdata;
          end
        end else begin
          cpu_ack <= 1'b1;
          if (!lat_we) begin
            cpu_rdata <= mem_rdata;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed bench for mem_arbiter. Instance A uses round-robin,
//            instance B gives the loader fixed priority. Each instance has
//            its own synchronous-read memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic clk;
  logic reset_n;

  // Instance A (round-robin)
  logic       a_cpu_req, a_cpu_we, a_cpu_ack;
  logic [7:0] a_cpu_addr, a_cpu_wdata, a_cpu_rdata;
  logic       a_ldr_req, a_ldr_we, a_ldr_ack;
  logic [7:0] a_ldr_addr, a_ldr_wdata, a_ldr_rdata;
  logic [7:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic       a_mem_we, a_owner, a_busy;

  // Instance B (loader priority)
  logic       b_cpu_req, b_cpu_we, b_cpu_ack;
  logic [7:0] b_cpu_addr, b_cpu_wdata, b_cpu_rdata;
  logic       b_ldr_req, b_ldr_we, b_ldr_ack;
  logic [7:0] b_ldr_addr, b_ldr_wdata, b_ldr_rdata;
  logic [7:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic       b_mem_we, b_owner, b_busy;

  logic [7:0] a_mem [0:255] = '{default: 8'h00};
  logic [7:0] b_mem [0:255] = '{default: 8'h00};

  int checks;
  int errors;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .LDR_PRIORITY(0)) u_dut_a (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr),
    .cpu_wdata(a_cpu_wdata), .cpu_ack(a_cpu_ack), .cpu_rdata(a_cpu_rdata),
    .ldr_req(a_ldr_req), .ldr_we(a_ldr_we), .ldr_addr(a_ldr_addr),
    .ldr_wdata(a_ldr_wdata), .ldr_ack(a_ldr_ack), .ldr_rdata(a_ldr_rdata),
    .mem_addr(a_mem_addr), .mem_we(a_mem_we), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .owner(a_owner), .busy(a_busy)
  );

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .LDR_PRIORITY(1)) u_dut_b (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr),
    .cpu_wdata(b_cpu_wdata), .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
    .ldr_req(b_ldr_req), .ldr_we(b_ldr_we), .ldr_addr(b_ldr_addr),
    .ldr_wdata(b_ldr_wdata), .ldr_ack(b_ldr_ack), .ldr_rdata(b_ldr_rdata),
    .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .owner(b_owner), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memories: address registered at the clock edge.
  always @(posedge clk) begin
    if (a_mem_we) a_mem[a_mem_addr] <= a_mem_wdata;
    a_mem_rdata <= a_mem[a_mem_addr];
    if (b_mem_we) b_mem[b_mem_addr] <= b_mem_wdata;
    b_mem_rdata <= b_mem[b_mem_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    a_cpu_req = 1'b1; a_cpu_we = 1'b1; a_cpu_addr = 8'h10; a_cpu_wdata = 8'h5A;
    a_ldr_req = 1'b0; a_ldr_we = 1'b0; a_ldr_addr = 8'h00; a_ldr_wdata = 8'h00;
    b_cpu_req = 1'b0; b_cpu_we = 1'b0; b_cpu_addr = 8'h00; b_cpu_wdata = 8'h00;
    b_ldr_req = 1'b0; b_ldr_we = 1'b0; b_ldr_addr = 8'h00; b_ldr_wdata = 8'h00;

    // ---- Reset held 2 cycles with cpu_req high ----
    tick; tick;
    check("reset_ctrl", {a_cpu_ack, a_ldr_ack, a_mem_we, a_owner, a_busy}, 0);
    check("reset_rdata", {a_cpu_rdata, a_ldr_rdata}, 0);
    check("reset_mem", {a_mem_addr, a_mem_wdata}, 0);
    reset_n = 1'b1;

    // ---- CPU write 0x5A -> 0x10 ----
    tick; // grant edge -> ISSUE
    check("wr_issue_ctrl", {a_busy, a_owner, a_mem_we}, 3'b101);
    check("wr_issue_addr", a_mem_addr, 8'h10);
    check("wr_issue_wdata", a_mem_wdata, 8'h5A);
    tick; // RESP
    check("wr_resp_ctrl", {a_busy, a_mem_we, a_cpu_ack}, 3'b100);
    check("wr_resp_addr", a_mem_addr, 8'h10);
    tick; // ack cycle
    check("wr_ack", {a_cpu_ack, a_ldr_ack, a_busy}, 3'b100);
    check("wr_rdata_kept", a_cpu_rdata, 8'h00);
    a_cpu_req = 1'b0;
    tick;
    check("wr_ack_pulse", {a_cpu_ack, a_busy}, 2'b00);
    check("wr_mem_content", a_mem[8'h10], 8'h5A);

    // ---- CPU read 0x10, req left high through the ack cycle ----
    a_cpu_req = 1'b1; a_cpu_we = 1'b0;
    tick;
    check("rd_issue", {a_busy, a_mem_we}, 2'b10);
    tick;
    tick;
    check("rd_ack", {a_cpu_ack, a_ldr_ack}, 2'b10);
    check("rd_data", a_cpu_rdata, 8'h5A);
    tick; // req still high during ack cycle: must be ignored
    check("rereq_ignored", {a_cpu_ack, a_busy}, 2'b00);
    tick;
    check("rereq_granted", {a_busy, a_owner}, 2'b10);
    a_cpu_req = 1'b0;
    tick;
    tick;
    check("rereq_ack", {a_cpu_ack, a_cpu_rdata}, {1'b1, 8'h5A});
    tick;
    check("rereq_idle", {a_cpu_ack, a_busy}, 2'b00);

    // ---- Round-robin: both held from reset ----
    reset_n = 1'b0;
    a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = 8'h10;
    a_ldr_req = 1'b1; a_ldr_we = 1'b1; a_ldr_addr = 8'h11; a_ldr_wdata = 8'hC3;
    tick;
    check("rr_reset_rdata", {a_cpu_rdata, a_ldr_rdata}, 0);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      check($sformatf("rr_owner_%0d", k), {a_busy, a_owner}, {1'b1, k[0]});
      tick;
      tick;
      if (k[0] == 1'b0) begin
        check($sformatf("rr_cpu_ack_%0d", k), {a_cpu_ack, a_ldr_ack}, 2'b10);
        check($sformatf("rr_cpu_rdata_%0d", k), a_cpu_rdata, 8'h5A);
      end else begin
        check($sformatf("rr_ldr_ack_%0d", k), {a_cpu_ack, a_ldr_ack}, 2'b01);
        check($sformatf("rr_ldr_rdata_%0d", k), a_ldr_rdata, (k == 1) ? 8'h00 : 8'hC3);
        a_ldr_we = 1'b0;
      end
    end
    a_cpu_req = 1'b0; a_ldr_req = 1'b0;
    tick;

    // ---- Loader priority (instance B): both held from reset ----
    reset_n = 1'b0;
    b_cpu_req = 1'b1; b_cpu_we = 1'b0; b_cpu_addr = 8'h40;
    b_ldr_req = 1'b1; b_ldr_we = 1'b1; b_ldr_addr = 8'h40; b_ldr_wdata = 8'h99;
    tick;
    reset_n = 1'b1;
    tick;
    check("prio_first_ldr", {b_busy, b_owner}, 2'b11);
    tick;
    tick;
    check("prio_ldr_ack", {b_ldr_ack, b_cpu_ack}, 2'b10);
    b_ldr_req = 1'b0;
    tick;
    check("prio_then_cpu", {b_busy, b_owner}, 2'b10);
    tick;
    tick;
    check("prio_cpu_ack", {b_cpu_ack, b_ldr_ack}, 2'b10);
    check("prio_cpu_rdata", b_cpu_rdata, 8'h99);
    b_cpu_req = 1'b0;
    tick;

    // ---- Reset during ISSUE of a loader write to 0x20 ----
    a_ldr_req = 1'b1; a_ldr_we = 1'b1; a_ldr_addr = 8'h20; a_ldr_wdata = 8'h3C;
    tick;
    check("mid_issue", {a_busy, a_owner, a_mem_we}, 3'b111);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_async_drop", {a_mem_we, a_busy, a_owner}, 3'b000);
    a_ldr_req = 1'b0;
    tick;
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      check($sformatf("mid_no_ack_%0d", k), {a_ldr_ack, a_busy}, 2'b00);
    end
    check("mid_no_write", a_mem[8'h20], 8'h00);
    a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = 8'h10;
    a_ldr_req = 1'b1; a_ldr_we = 1'b0; a_ldr_addr = 8'h20;
    tick;
    check("mid_tie_cpu", {a_busy, a_owner}, 2'b10);
    tick;
    tick;
    check("mid_tie_ack", {a_cpu_ack, a_ldr_ack, a_cpu_rdata}, {2'b10, 8'h5A});
    a_cpu_req = 1'b0; a_ldr_req = 1'b0;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
